// File: rtl/pe_code_decoder_pkg.sv
// Shared types, code-space constants and decode helpers for the priority-encoder
// code path (the encoder side uses the same constants).
package pe_code_decoder_pkg;

    localparam int PE_CODE_W = 4;
    localparam int PE_NUM_IN = 8;

    typedef logic [PE_CODE_W-1:0] pe_code_t;
    typedef logic [PE_NUM_IN-1:0] pe_onehot_t;

    localparam pe_code_t PE_CODE_NONE = 4'd0;
    localparam pe_code_t PE_CODE_MAX  = 4'd8;

    typedef enum logic [1:0] {
        CODE_NONE    = 2'd0,
        CODE_LEGAL   = 2'd1,
        CODE_ILLEGAL = 2'd2
    } code_kind_t;

    function automatic code_kind_t classify(input pe_code_t code);
        if (code == PE_CODE_NONE) return CODE_NONE;
        if (code <= PE_CODE_MAX) return CODE_LEGAL;
        return CODE_ILLEGAL;
    endfunction

    // Code k (1..8) sets bit k-1; anything else decodes to all-zero.
    function automatic pe_onehot_t code_to_onehot(input pe_code_t code);
        pe_onehot_t v;
        v = '0;
        for (int i = 0; i < PE_NUM_IN; i++) begin
            if (code == pe_code_t'(i + 1)) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pe_code_decoder_if.sv
// Code-in / one-hot-out stream bundle between encoder, decoder and downstream logic.
interface pe_code_decoder_if;
    import pe_code_decoder_pkg::*;

    // Both streams: a beat transfers on a rising edge where valid && ready;
    // the source holds payload stable while valid && !ready.
    pe_code_t   in_code;
    logic       in_valid;
    logic       in_ready;
    pe_onehot_t out_onehot;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_code, in_valid, out_ready,
        input  in_ready, out_onehot, out_valid
    );

    modport slave (
        input  in_code, in_valid, out_ready,
        output in_ready, out_onehot, out_valid
    );

endinterface

// File: rtl/pe_code_fifo.sv
// Synchronous FIFO with occupancy counter; push ignored when full, pop ignored
// when empty. DEPTH must be a power of two so pointers wrap naturally.
module pe_code_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the read side is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pe_code_decoder.sv
// Consumer end of the priority-encoder code path: filters codes, buffers legal
// ones, presents them one-hot, and keeps idle/event counters and a sticky error.
module pe_code_decoder
    import pe_code_decoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pe_code_decoder_if.slave     bus,
    output logic                 err_illegal,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     idle_cnt,
    output logic [CNT_W-1:0]     evt_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    code_kind_t kind;
    pe_code_t   head;
    logic       accept;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;

    assign kind = classify(bus.in_code);

    // Every code consumes a transfer; only legal ones occupy FIFO space.
    assign bus.in_ready  = rst_n && !full;
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = accept && (kind == CODE_LEGAL);
    assign bus.out_valid = !empty;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_onehot = empty ? '0 : code_to_onehot(head);

    pe_code_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PE_CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (bus.in_code),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
            idle_cnt    <= '0;
            evt_cnt     <= '0;
        end else begin
            // A new illegal code outranks a concurrent clear.
            if (accept && (kind == CODE_ILLEGAL)) err_illegal <= 1'b1;
            else if (err_clr)                      err_illegal <= 1'b0;

            if (accept && (kind == CODE_NONE) && (idle_cnt != CNT_MAX))
                idle_cnt <= idle_cnt + CNT_W'(1);

            if (pop && (evt_cnt != CNT_MAX))
                evt_cnt <= evt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pe_code_decoder.sv
// Self-checking bench for pe_code_decoder: table vectors, directed corner
// sequences and a random stream, all checked through an expected-output queue.
module tb_pe_code_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       err_clr = 1'b0;
    logic       err_illegal;
    logic [7:0] idle_cnt;
    logic [7:0] evt_cnt;
    logic       err_illegal2;
    logic [1:0] idle_cnt2;
    logic [1:0] evt_cnt2;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic [3:0] code;
        logic [7:0] exp;
        logic       legal;
    } vec_t;

    vec_t vecs[16];

    pe_code_decoder_if bus ();
    pe_code_decoder_if bus2 ();

    pe_code_decoder #(.DEPTH(2), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .err_illegal (err_illegal),
        .err_clr     (err_clr),
        .idle_cnt    (idle_cnt),
        .evt_cnt     (evt_cnt)
    );

    pe_code_decoder #(.DEPTH(2), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus2),
        .err_illegal (err_illegal2),
        .err_clr     (err_clr),
        .idle_cnt    (idle_cnt2),
        .evt_cnt     (evt_cnt2)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: compare each delivered vector with the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out_valid", {31'b0, bus.out_valid}, 32'd0);
                else check("scoreboard_onehot", {24'b0, bus.out_onehot}, {24'b0, exp_q.pop_front()});
            end
            if (!bus.out_valid) check("idle_onehot_zero", {24'b0, bus.out_onehot}, 32'd0);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] code, input logic [7:0] exp, input logic legal,
                        output int stalls);
        stalls = 0;
        bus.in_code  = code;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("send_in_ready", {31'b0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            if (legal) exp_q.push_back(exp);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0;
        err_clr = 1'b0;
        #2;
        exp_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        sync();
    endtask

    initial begin
        int st;
        int st3;
        int n_zero;
        int n_legal;
        int n_illegal;
        logic [7:0] stream_exp[8];

        vecs[0]  = '{4'd5,  8'h10, 1'b1};
        vecs[1]  = '{4'd0,  8'h00, 1'b0};
        vecs[2]  = '{4'd9,  8'h00, 1'b0};
        vecs[3]  = '{4'd1,  8'h01, 1'b1};
        vecs[4]  = '{4'd8,  8'h80, 1'b1};
        vecs[5]  = '{4'd15, 8'h00, 1'b0};
        vecs[6]  = '{4'd3,  8'h04, 1'b1};
        vecs[7]  = '{4'd10, 8'h00, 1'b0};
        vecs[8]  = '{4'd2,  8'h02, 1'b1};
        vecs[9]  = '{4'd11, 8'h00, 1'b0};
        vecs[10] = '{4'd7,  8'h40, 1'b1};
        vecs[11] = '{4'd12, 8'h00, 1'b0};
        vecs[12] = '{4'd4,  8'h08, 1'b1};
        vecs[13] = '{4'd13, 8'h00, 1'b0};
        vecs[14] = '{4'd6,  8'h20, 1'b1};
        vecs[15] = '{4'd14, 8'h00, 1'b0};
        stream_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        bus.in_code = 4'd0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus2.in_code = 4'd0;
        bus2.in_valid = 1'b0;
        bus2.out_ready = 1'b1;

        // reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_onehot", {24'b0, bus.out_onehot}, 32'd0);
        check("rst_err_illegal", {31'b0, err_illegal}, 32'd0);
        check("rst_idle_cnt", {24'b0, idle_cnt}, 32'd0);
        check("rst_evt_cnt", {24'b0, evt_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // reset mid-stream discards buffered codes
        sync();
        send(4'd2, 8'h02, 1'b1, st);
        send(4'd6, 8'h20, 1'b1, st);
        @(negedge clk);
        check("mid_full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_out_onehot", {24'b0, bus.out_onehot}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("mid_release_out_valid", {31'b0, bus.out_valid}, 32'd0);

        // single code, one-cycle latency
        do_reset();
        bus.out_ready = 1'b1;
        send(4'd3, 8'h04, 1'b1, st);
        @(negedge clk);
        check("single_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("single_out_onehot", {24'b0, bus.out_onehot}, 32'h04);
        @(negedge clk);
        check("single_out_valid_drop", {31'b0, bus.out_valid}, 32'd0);
        check("single_evt_cnt", {24'b0, evt_cnt}, 32'd1);

        // back-pressure: full FIFO stalls input, head holds, order kept
        do_reset();
        send(4'd8, 8'h80, 1'b1, st);
        send(4'd1, 8'h01, 1'b1, st);
        @(negedge clk);
        check("bp_in_ready_full", {31'b0, bus.in_ready}, 32'd0);
        check("bp_head", {24'b0, bus.out_onehot}, 32'h80);
        sync();
        fork
            send(4'd5, 8'h10, 1'b1, st3);
            begin
                repeat (3) @(negedge clk);
                check("bp_hold_onehot", {24'b0, bus.out_onehot}, 32'h80);
                check("bp_hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
                sync();
                bus.out_ready = 1'b1;
            end
        join
        check("bp_stalled", {31'b0, st3 >= 3}, 32'd1);
        wait_drain();
        @(negedge clk);
        check("bp_evt_cnt", {24'b0, evt_cnt}, 32'd3);

        // filtering: none / illegal codes never reach the output
        do_reset();
        bus.out_ready = 1'b1;
        send(4'd0, 8'h00, 1'b0, st);
        send(4'd0, 8'h00, 1'b0, st);
        send(4'd12, 8'h00, 1'b0, st);
        @(negedge clk);
        check("filt_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("filt_idle_cnt", {24'b0, idle_cnt}, 32'd2);
        check("filt_err", {31'b0, err_illegal}, 32'd1);
        sync();
        err_clr = 1'b1;
        send(4'd15, 8'h00, 1'b0, st);
        err_clr = 1'b0;
        @(negedge clk);
        check("filt_set_wins", {31'b0, err_illegal}, 32'd1);
        check("filt_evt_cnt", {24'b0, evt_cnt}, 32'd0);
        sync();
        err_clr = 1'b1;
        sync();
        err_clr = 1'b0;
        @(negedge clk);
        check("filt_clr_alone", {31'b0, err_illegal}, 32'd0);

        // table of every code value
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(vecs[i].code, vecs[i].exp, vecs[i].legal, st);
        wait_drain();
        @(negedge clk);
        check("tbl_idle_cnt", {24'b0, idle_cnt}, 32'd1);
        check("tbl_err", {31'b0, err_illegal}, 32'd1);
        check("tbl_evt_cnt", {24'b0, evt_cnt}, 32'd8);

        // streaming with no back-pressure: never stalls
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(4'(i + 1), stream_exp[i], 1'b1, st);
            check("stream_no_stall", st, 32'd0);
        end
        wait_drain();
        @(negedge clk);
        check("stream_evt_cnt", {24'b0, evt_cnt}, 32'd8);

        // random codes against random back-pressure
        do_reset();
        n_zero = 0;
        n_legal = 0;
        n_illegal = 0;
        fork
            for (int i = 0; i < 40; i++) begin
                int c;
                logic [7:0] e;
                c = $urandom_range(0, 15);
                e = '0;
                if (c >= 1 && c <= 8) e[c-1] = 1'b1;
                if (c == 0) n_zero++;
                else if (c <= 8) n_legal++;
                else n_illegal++;
                send(4'(c), e, (c >= 1 && c <= 8), st);
            end
            repeat (80) begin
                sync();
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("rand_idle_cnt", {24'b0, idle_cnt}, n_zero);
        check("rand_evt_cnt", {24'b0, evt_cnt}, n_legal);
        check("rand_err", {31'b0, err_illegal}, {31'b0, n_illegal != 0});

        // saturation on the narrow-counter instance
        do_reset();
        bus2.in_code = 4'd0;
        bus2.in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sync();
            check("sat_idle_cnt", {30'b0, idle_cnt2}, (k < 3) ? k : 3);
        end
        bus2.in_valid = 1'b0;
        @(negedge clk);
        check("sat_idle_hold", {30'b0, idle_cnt2}, 32'd3);
        check("sat_out_valid", {31'b0, bus2.out_valid}, 32'd0);
        check("sat_evt_cnt", {30'b0, evt_cnt2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
